// File: rtl/writeback_stage.sv
`default_nettype none
// writeback_stage: in-order pending-write buffer draining ALU/load results to the RF write
// port, with decode bypass lookup when WB_BYPASS_EN is defined. Rev 1.0
module writeback_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  input  logic                      ld_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ld_rd,
  input  logic [DATA_WIDTH-1:0]     ld_data,
  output logic                      stall,
  output logic                      overflow,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  input  logic [REG_ADDR_WIDTH-1:0] byp_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] byp_rs2,
  output logic                      byp_hit1,
  output logic [DATA_WIDTH-1:0]     byp_data1,
  output logic                      byp_hit2,
  output logic [DATA_WIDTH-1:0]     byp_data2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [REG_ADDR_WIDTH-1:0] rd_mem   [DEPTH];
  logic [DATA_WIDTH-1:0]     data_mem [DEPTH];
  logic [PTR_W-1:0]          head;
  logic [PTR_W-1:0]          tail;
  logic [PTR_W-1:0]          alu_slot;
  logic [CNT_W-1:0]          count;
  logic [CNT_W-1:0]          free;
  logic                      ld_ok;
  logic                      alu_ok;
  logic                      ld_acc;
  logic                      alu_acc;
  logic                      deq;
  logic [1:0]                enq_n;

  // Drain is not credited to free space, so at most DEPTH-1 entries are live after any edge.
  assign free     = DEPTH_C - count;
  assign ld_ok    = ld_valid && (ld_rd != '0);
  assign alu_ok   = alu_valid && (alu_rd != '0);
  assign ld_acc   = ld_ok && (free != '0);
  assign alu_acc  = alu_ok && (ld_acc ? (free >= CNT_W'(2)) : (free != '0));
  assign deq      = (count != '0);
  assign enq_n    = {1'b0, ld_acc} + {1'b0, alu_acc};
  assign alu_slot = tail + PTR_W'(ld_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      head  <= head + PTR_W'(deq);
      tail  <= tail + PTR_W'(enq_n);
      count <= count + CNT_W'(enq_n) - CNT_W'(deq);
      if ((ld_ok && !ld_acc) || (alu_ok && !alu_acc)) begin
        overflow <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset; validity is tracked by head/count only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (ld_acc) begin
        rd_mem[tail]   <= ld_rd;
        data_mem[tail] <= ld_data;
      end
      if (alu_acc) begin
        rd_mem[alu_slot]   <= alu_rd;
        data_mem[alu_slot] <= alu_data;
      end
    end
  end

  assign rf_we    = !rst && deq;
  assign rf_waddr = rf_we ? rd_mem[head] : '0;
  assign rf_wdata = rf_we ? data_mem[head] : '0;
  assign stall    = !rst && (free < CNT_W'(2));

`ifdef WB_BYPASS_EN
  logic [PTR_W-1:0] scan_idx;

  // Scan oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    byp_hit1  = 1'b0;
    byp_data1 = '0;
    byp_hit2  = 1'b0;
    byp_data2 = '0;
    scan_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PTR_W'(i);
      if (!rst && (CNT_W'(i) < count)) begin
        if ((byp_rs1 != '0) && (rd_mem[scan_idx] == byp_rs1)) begin
          byp_hit1  = 1'b1;
          byp_data1 = data_mem[scan_idx];
        end
        if ((byp_rs2 != '0) && (rd_mem[scan_idx] == byp_rs2)) begin
          byp_hit2  = 1'b1;
          byp_data2 = data_mem[scan_idx];
        end
      end
    end
  end
`else
  logic unused_byp;

  assign unused_byp = ^{byp_rs1, byp_rs2};
  assign byp_hit1   = 1'b0;
  assign byp_data1  = '0;
  assign byp_hit2   = 1'b0;
  assign byp_data2  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// tb_writeback_stage: directed and randomized checks of writeback_stage against a queue model.
module tb_writeback_stage;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, ld_valid;
  logic [AW-1:0] alu_rd, ld_rd, byp_rs1, byp_rs2;
  logic [DW-1:0] alu_data, ld_data;
  logic          stall, overflow, rf_we, byp_hit1, byp_hit2;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata, byp_data1, byp_data2;

  always #5 clk = ~clk;

  writeback_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .stall(stall), .overflow(overflow),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .byp_rs1(byp_rs1), .byp_rs2(byp_rs2),
    .byp_hit1(byp_hit1), .byp_data1(byp_data1),
    .byp_hit2(byp_hit2), .byp_data2(byp_data2)
  );

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t q[$];
  bit   m_ovf;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: pending writes as a queue in program order.
  function automatic bit e_we();
    return !rst && (q.size() > 0);
  endfunction

  function automatic logic [AW-1:0] e_waddr();
    return e_we() ? q[0].rd : '0;
  endfunction

  function automatic logic [DW-1:0] e_wdata();
    return e_we() ? q[0].data : '0;
  endfunction

  function automatic bit e_stall();
    return !rst && ((DEPTH - q.size()) < 2);
  endfunction

  function automatic bit e_hit(input logic [AW-1:0] rs);
    if (!BYP || rst || rs == '0) return 1'b0;
    foreach (q[i]) if (q[i].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] e_byp(input logic [AW-1:0] rs);
    if (!BYP || rst || rs == '0) return '0;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].rd == rs) return q[i].data;
    return '0;
  endfunction

  task automatic tick();
    int  room;
    bit  l, a;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      room = DEPTH - q.size();
      l = ld_valid && (ld_rd != '0);
      a = alu_valid && (alu_rd != '0);
      if (q.size() > 0) void'(q.pop_front());
      if (l) begin
        if (room > 0) begin q.push_back('{rd: ld_rd, data: ld_data}); room--; end
        else m_ovf = 1'b1;
      end
      if (a) begin
        if (room > 0) begin q.push_back('{rd: alu_rd, data: alu_data}); room--; end
        else m_ovf = 1'b1;
      end
    end
    #2;
  endtask

  task automatic drive(input bit lv, input int lrd, input logic [DW-1:0] ldd,
                       input bit av, input int ard, input logic [DW-1:0] ad);
    ld_valid  = lv;  ld_rd  = AW'(lrd); ld_data  = ldd;
    alu_valid = av;  alu_rd = AW'(ard); alu_data = ad;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(1, 7, 32'h1234, 1, 9, 32'h5678);
      n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", rf_we); end
      n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
      tick();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we_after: got %b want 0", rf_we); end
    n_cmp++; if (rf_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
    tick();
  endtask

  task automatic test_single_alu();
    drive(0, 0, 0, 1, 5, 32'hDEADBEEF);
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL single_nothru: got %b want 0", rf_we); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_write: got we=%b a=%0d d=%h want 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL single_once: got %b want 0", rf_we); end
    drive(1, 0, 32'h77, 1, 0, 32'h99);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rd0_we: got %b want 0", rf_we); end
      tick();
    end
  endtask

  task automatic test_dual_retire();
    byp_rs1 = 5'd3; byp_rs2 = 5'd0;
    drive(1, 3, 32'h11, 1, 3, 32'h22);
    n_cmp++; if (byp_hit1 !== 1'b0) begin n_fail++; $display("FAIL dual_arrival_hidden: got %b want 0", byp_hit1); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin
      n_fail++; $display("FAIL dual_first: got we=%b a=%0d d=%h want 1/3/11", rf_we, rf_waddr, rf_wdata);
    end
    n_cmp++; if (byp_hit1 !== BYP || byp_data1 !== (BYP ? 32'h22 : 32'h0)) begin
      n_fail++; $display("FAIL dual_byp_young: got hit=%b d=%h want %b/%h", byp_hit1, byp_data1, BYP, BYP ? 32'h22 : 32'h0);
    end
    n_cmp++; if (byp_hit2 !== 1'b0 || byp_data2 !== '0) begin
      n_fail++; $display("FAIL dual_byp_x0: got hit=%b d=%h want 0/0", byp_hit2, byp_data2);
    end
    tick();
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h22) begin
      n_fail++; $display("FAIL dual_second: got we=%b a=%0d d=%h want 1/3/22", rf_we, rf_waddr, rf_wdata);
    end
    n_cmp++; if (byp_hit1 !== BYP || byp_data1 !== (BYP ? 32'h22 : 32'h0)) begin
      n_fail++; $display("FAIL dual_byp_head: got hit=%b d=%h want %b", byp_hit1, byp_data1, BYP);
    end
    tick();
    n_cmp++; if (rf_we !== 1'b0 || byp_hit1 !== 1'b0) begin
      n_fail++; $display("FAIL dual_empty: got we=%b hit=%b want 0/0", rf_we, byp_hit1);
    end
  endtask

  task automatic test_fill_overflow();
    int exp_a [5] = '{1, 2, 3, 4, 5};
    drive(1, 1, 32'hA1, 1, 2, 32'hA2);
    tick();
    drive(1, 3, 32'hB3, 1, 4, 32'hB4);
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fill_stall2: got %b want 0", stall); end
    n_cmp++; if (rf_waddr !== 5'd1) begin n_fail++; $display("FAIL fill_w1: got %0d want 1", rf_waddr); end
    tick();
    drive(1, 5, 32'hC5, 1, 6, 32'hC6);
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fill_stall3: got %b want 1", stall); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_early: got %b want 0", overflow); end
    n_cmp++; if (rf_waddr !== 5'd2) begin n_fail++; $display("FAIL fill_w2: got %0d want 2", rf_waddr); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 2; k < 5; k++) begin
      n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== AW'(exp_a[k]) || overflow !== 1'b1) begin
        n_fail++; $display("FAIL fill_drain%0d: got we=%b a=%0d ovf=%b want 1/%0d/1", k, rf_we, rf_waddr, overflow, exp_a[k]);
      end
      tick();
    end
    n_cmp++; if (rf_we !== 1'b0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL fill_end: got we=%b ovf=%b want 0/1", rf_we, overflow);
    end
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_wrap();
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) drive(0, 0, 0, 1, k + 1, 32'(k + 1) * 32'h100);
      else drive(0, 0, 0, 0, 0, 0);
      if (k == 0) begin
        n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL wrap_start: got %b want 0", rf_we); end
      end else begin
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== AW'(k) || rf_wdata !== 32'(k) * 32'h100 || stall !== 1'b0) begin
          n_fail++; $display("FAIL wrap_%0d: got we=%b a=%0d d=%h st=%b want 1/%0d/%h/0", k, rf_we, rf_waddr, rf_wdata, stall, k, 32'(k) * 32'h100);
        end
      end
      tick();
    end
    n_cmp++; if (rf_we !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL wrap_end: got we=%b ovf=%b want 0/0", rf_we, overflow);
    end
  endtask

  task automatic test_reset_mid_drain();
    byp_rs1 = 5'd3; byp_rs2 = 5'd4;
    drive(1, 1, 32'h10, 1, 2, 32'h20);
    tick();
    drive(1, 3, 32'h30, 1, 4, 32'h40);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++; if (rf_we !== 1'b1 || byp_hit1 !== BYP) begin
      n_fail++; $display("FAIL mid_pending: got we=%b hit=%b want 1/%b", rf_we, byp_hit1, BYP);
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) rst = 1'b0;
      #1;
      n_cmp++; if (rf_we !== 1'b0 || byp_hit1 !== 1'b0 || byp_hit2 !== 1'b0 || byp_data1 !== '0 || stall !== 1'b0) begin
        n_fail++; $display("FAIL mid_reset%0d: got we=%b h1=%b h2=%b d1=%h st=%b want all 0", c, rf_we, byp_hit1, byp_hit2, byp_data1, stall);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit lv, av;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      lv = ($urandom_range(0, 2) != 0);
      av = ($urandom_range(0, 2) != 0);
      if (stall && ($urandom_range(0, 9) < 8)) begin lv = 1'b0; av = 1'b0; end
      rst     = ($urandom_range(0, 49) == 0);
      byp_rs1 = AW'($urandom_range(0, 7));
      byp_rs2 = AW'($urandom_range(0, 7));
      drive(lv, $urandom_range(0, 7), $urandom, av, $urandom_range(0, 7), $urandom);
      n_cmp++; if (rf_we !== e_we() || rf_waddr !== e_waddr() || rf_wdata !== e_wdata()) begin
        n_fail++; $display("FAIL rnd_rf c=%0d: got %b/%0d/%h want %b/%0d/%h", c, rf_we, rf_waddr, rf_wdata, e_we(), e_waddr(), e_wdata());
      end
      n_cmp++; if (stall !== e_stall() || overflow !== m_ovf) begin
        n_fail++; $display("FAIL rnd_flags c=%0d: got st=%b ovf=%b want %b/%b", c, stall, overflow, e_stall(), m_ovf);
      end
      n_cmp++; if (byp_hit1 !== e_hit(byp_rs1) || byp_data1 !== e_byp(byp_rs1) ||
                   byp_hit2 !== e_hit(byp_rs2) || byp_data2 !== e_byp(byp_rs2)) begin
        n_fail++; $display("FAIL rnd_byp c=%0d: got %b/%h %b/%h want %b/%h %b/%h", c, byp_hit1, byp_data1, byp_hit2, byp_data2,
                           e_hit(byp_rs1), e_byp(byp_rs1), e_hit(byp_rs2), e_byp(byp_rs2));
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    byp_rs1 = '0; byp_rs2 = '0;
    test_reset();
    test_single_alu();
    test_dual_retire();
    test_fill_overflow();
    test_wrap();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
